// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_ext: address/count width derivation and
// parameter-legality checks evaluated at elaboration.
package sync_fifo_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = 1;
      while (x < v) begin
         x = x << 1;
         r++;
      end
      return r;
   endfunction

   function automatic int unsigned addr_w(input int unsigned depth);
      return clog2(depth);
   endfunction

   // One extra bit so a completely full FIFO (count == depth) is representable.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit params_legal(input int unsigned dw,
                                       input int unsigned depth,
                                       input int unsigned af,
                                       input int unsigned ae);
      return (dw >= 1) && (depth >= 4) && is_pow2(depth) &&
             (af >= 1) && (af <= depth - 1) &&
             (ae >= 1) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port and one read port that is
// either registered (REG_READ=1, output reset to zero) or combinational.
module fifo_mem_dp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_W     = 4,
   parameter bit          REG_READ   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (REG_READ) begin : g_reg_read
         logic [DATA_WIDTH-1:0] rdata_q;
         logic [DATA_WIDTH-1:0] rdata_d;

         always_comb begin
            rdata_d = rdata_q;
            if (re) begin
               rdata_d = mem_q[raddr];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               rdata_q <= '0;
            end else begin
               rdata_q <= rdata_d;
            end
         end

         assign rdata = rdata_q;
      end else begin : g_comb_read
         // re acts as "head valid": the port shows zero while nothing is stored.
         logic unused_reset;
         assign unused_reset = reset;
         assign rdata        = re ? mem_q[raddr] : '0;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_ext
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned AF_THRESH  = 14,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr_en,
   input  logic [DATA_WIDTH-1:0]            din,
   input  logic                             rd_en,
   output logic [DATA_WIDTH-1:0]            dout,
   output logic                             full,
   output logic                             empty,
   output logic                             almost_full,
   output logic                             almost_empty,
   output logic [cnt_w(FIFO_DEPTH)-1:0]     count,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int unsigned ADDR_W = addr_w(FIFO_DEPTH);
   localparam int unsigned CNT_W  = cnt_w(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

   generate
      if (!params_legal(DATA_WIDTH, FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
         $error("sync_fifo_ext: illegal parameters (depth must be pow2 >= 4, thresholds 1..depth-1)");
      end
   endgenerate

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              af_q, af_d;
   logic              ae_q, ae_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              wr_acc;
   logic              rd_acc;
   logic              mem_re;

   // Acceptance looks only at the registered flags from the previous edge.
   always_comb begin
      rd_acc   = rd_en && !empty_q;
      wr_acc   = wr_en && (!full_q || rd_en);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CNT_W'(1);
      end

      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
      af_d    = (count_d >= AF_C);
      ae_d    = (count_d <= AE_C);
      ovf_d   = wr_en && !wr_acc;
      udf_d   = rd_en && !rd_acc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   localparam bit REG_READ = 1'b0;
   // Head word is visible whenever something is stored; the pointer move pops it.
   assign mem_re = !empty_q;
`else
   localparam bit REG_READ = 1'b1;
   assign mem_re = rd_acc;
`endif

   fifo_mem_dp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_W     (ADDR_W),
      .REG_READ   (REG_READ)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (din),
      .re    (mem_re),
      .raddr (rd_ptr_q),
      .rdata (dout)
   );

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: a queue-based reference model predicts every
// cycle's outputs; a monitor compares them just after each rising edge.
module tb_sync_fifo_ext;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] din = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] dout;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]    count;

   sync_fifo_ext #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .dout         (dout),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      int            cnt;
      bit            full;
      bit            empty;
      bit            af;
      bit            ae;
      bit            ovf;
      bit            udf;
      bit            chk_d;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] model_dout = '0;
   int            total = 0;
   int            bad = 0;
   int            cyc_n = 0;

   task automatic chk(input string name, input int cyc, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   // Reference model: plain queue semantics, applied to the inputs of one cycle.
   task automatic predict(input bit rst, input bit wr, input logic [DW-1:0] d, input bit rd);
      exp_t e;
      int   n;
      bit   rd_ok, wr_ok;
      e.ovf = 1'b0;
      e.udf = 1'b0;
      if (rst) begin
         model_q.delete();
         model_dout = '0;
      end else begin
         n     = model_q.size();
         rd_ok = rd && (n > 0);
         wr_ok = wr && ((n < DEPTH) || rd);
         e.ovf = wr && !wr_ok;
         e.udf = rd && !rd_ok;
         if (rd_ok) model_dout = model_q.pop_front();
         if (wr_ok) model_q.push_back(d);
      end
      e.cyc   = cyc_n;
      e.cnt   = model_q.size();
      e.full  = (e.cnt == DEPTH);
      e.empty = (e.cnt == 0);
      e.af    = (e.cnt >= AF);
      e.ae    = (e.cnt <= AE);
      if (FWFT) begin
         e.chk_d = (e.cnt > 0);
         e.d     = (e.cnt > 0) ? model_q[0] : '0;
      end else begin
         e.chk_d = 1'b1;
         e.d     = model_dout;
      end
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit rst, input bit wr, input logic [DW-1:0] d, input bit rd);
      @(negedge clk);
      reset = rst;
      wr_en = wr;
      din   = d;
      rd_en = rd;
      predict(rst, wr, d, rd);
      cyc_n++;
      @(posedge clk);
   endtask

   task automatic wr1(input logic [DW-1:0] d); cyc(1'b0, 1'b1, d, 1'b0); endtask
   task automatic rd1();                      cyc(1'b0, 1'b0, '0, 1'b1); endtask
   task automatic idle();                     cyc(1'b0, 1'b0, '0, 1'b0); endtask

   // Monitor: every edge has exactly one expectation queued before it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("count",        e.cyc, int'(count),        e.cnt);
         chk("full",         e.cyc, int'(full),         int'(e.full));
         chk("empty",        e.cyc, int'(empty),        int'(e.empty));
         chk("almost_full",  e.cyc, int'(almost_full),  int'(e.af));
         chk("almost_empty", e.cyc, int'(almost_empty), int'(e.ae));
         chk("overflow",     e.cyc, int'(overflow),     int'(e.ovf));
         chk("underflow",    e.cyc, int'(underflow),    int'(e.udf));
         if (e.chk_d) chk("dout", e.cyc, int'(dout), int'(e.d));
      end
   end

   initial begin
      int pw, pr;

      // 1: small write/read sequence
      cyc(1'b1, 1'b0, '0, 1'b0);
      cyc(1'b1, 1'b0, '0, 1'b0);
      wr1(8'hC4); wr1(8'hC4); wr1(8'hFF);
      rd1(); rd1(); rd1();
      idle();

      // 2: fill to full, then one rejected write
      for (int i = 0; i < DEPTH; i++) wr1(8'(i));
      wr1(8'h77);
      idle();

      // 3: simultaneous write/read while full
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hAA, 1'b1);
      for (int i = 0; i < DEPTH; i++) rd1();

      // 4: underflow alone, then write+read on empty
      rd1();
      idle();
      cyc(1'b0, 1'b1, 8'h5A, 1'b1);
      rd1();
      idle();

      // 5: steady occupancy 8 across pointer wrap
      for (int i = 0; i < 8; i++) wr1(8'($urandom));
      for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b1);

      // 6: reset at occupancy 9, then a single word through
      wr1(8'h99);
      cyc(1'b1, 1'b1, 8'h11, 1'b1);
      wr1(8'h3C);
      rd1();
      idle();

      // Random traffic with phases biased toward full, empty and balanced
      for (int ph = 0; ph < 6; ph++) begin
         case (ph % 3)
            0:       begin pw = 85; pr = 25; end
            1:       begin pw = 20; pr = 80; end
            default: begin pw = 55; pr = 55; end
         endcase
         for (int i = 0; i < 80; i++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 99) < pw),
                8'($urandom),
                ($urandom_range(0, 99) < pr));
         end
      end
      idle();

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", cyc_n, exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
